// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the producer write port, the FIFO status flags and the transmitter
// start/busy handshake of uart_tx_fifo into one connection.
//
// Signals:
//   wr_en, wr_data  producer write strobe and byte
//   clr_ovf         producer request to clear the sticky overflow flag
//   full, empty     FIFO occupancy flags
//   count           bytes currently stored (0..DEPTH)
//   overflow        sticky flag, set by a write attempted while full
//   tx_start        one-cycle start pulse towards the UART transmitter
//   tx_data         byte for the transmitter, held between starts
//   tx_busy         transmitter busy flag
//
// Modports:
//   master  environment side (producer + transmitter)
//   slave   the FIFO itself
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              clr_ovf;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_busy,
        input  full, empty, count, overflow, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_busy,
        output full, empty, count, overflow, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO in front of the UART transmitter. Producers push bytes at full
// clock rate; a small drain FSM hands them to the transmitter one at a time
// through its start/busy handshake.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    uart_tx_fifo_if.slave: write port, status flags, overflow
//          clear and the tx_start/tx_data/tx_busy handshake
//
// Parameters:
//   DEPTH         FIFO entries, power of two, at least 2
//   BUSY_TIMEOUT  cycles to wait for tx_busy after a start before the byte
//                 is considered sent anyway
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]        TO_LAST   = 3'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_ovf;
    state_t            r_state;
    logic [2:0]        r_to_cnt;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;

    logic              w_wr_acc;
    logic              w_ovf_set;
    logic              w_pop;
    logic [ADDR_W:0]   w_count_nxt;

    // Write acceptance, overflow event and pop decision for this cycle.
    // full is judged on the registered (pre-pop) count, so a write that
    // lands on a full FIFO is dropped even if a pop happens in the same cycle.
    always_comb begin
        w_wr_acc  = bus.wr_en & ~r_full;
        w_ovf_set = bus.wr_en & r_full;
        w_pop     = (r_state == ST_IDLE) & ~r_empty & ~bus.tx_busy;
    end

    // Next occupancy; a simultaneous accepted write and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wp] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= PTR_ZERO;
            r_rp    <= PTR_ZERO;
            r_count <= CNT_ZERO;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_DEPTH);
            r_empty <= (w_count_nxt == CNT_ZERO);
        end
    end

    // Sticky overflow flag; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    // Drain FSM: issues one start per byte, then waits for the transmitter
    // to go busy and idle again. If busy never rises within BUSY_TIMEOUT
    // cycles the byte is treated as sent so a dead transmitter cannot hang
    // the queue. IDLE only starts when tx_busy=0, which also covers a byte
    // still in flight across a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_to_cnt   <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= 3'd0;
                    if (w_pop) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_mem[r_rp];
                        r_state    <= ST_WAIT_BUSY;
                    end else begin
                        r_tx_start <= 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    r_tx_start <= 1'b0;
                    if (bus.tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 3'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    r_tx_start <= 1'b0;
                    if (!bus.tx_busy) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_to_cnt   <= 3'd0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_ovf;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A queue-based reference model tracks
// which bytes should be stored and in what order; a transmitter model answers
// tx_start with a configurable busy period.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    uart_tx_fifo_if u_if ();

    uart_tx_fifo u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // transmitter model controls
    logic force_busy = 1'b0;
    int   busy_len   = 0;
    logic rand_busy  = 1'b0;
    int   busy_cnt   = 0;

    // reference model state
    logic [7:0] model_q[$];
    logic       model_ovf  = 1'b0;
    logic [7:0] last_data  = 8'h00;
    int         n_starts   = 0;
    int         cyc        = 0;
    int         start_times[$];
    logic       prev_start = 1'b0;
    logic       pend_rst   = 1'b0;
    logic       pend_wr    = 1'b0;
    logic [7:0] pend_data  = 8'h00;
    logic       pend_clr   = 1'b0;
    logic       pend_busy  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign u_if.tx_busy = force_busy || (busy_cnt != 0);

    // transmitter model: busy for busy_len cycles after each start
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (u_if.tx_start) begin
                if (rand_busy) busy_cnt = $urandom_range(0, 5);
                else           busy_cnt = busy_len;
            end
        end
    end

    // reference model and per-cycle checks, sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0] exp_b;
        cyc++;
        if (!pend_rst) begin
            model_q.delete();
            model_ovf = 1'b0;
            last_data = 8'h00;
            check_eq("rst_start", u_if.tx_start, 0);
            check_eq("rst_data", u_if.tx_data, 0);
        end else begin
            if (pend_wr && model_q.size() < DEPTH) model_q.push_back(pend_data);
            if (pend_wr && model_q.size() >= DEPTH && !(model_q.size() == DEPTH && model_q[DEPTH-1] === pend_data && 0))
                ;
            if (u_if.tx_start) begin
                n_starts++;
                start_times.push_back(cyc);
                check_eq("start_while_busy", pend_busy, 0);
                check_eq("start_double", prev_start, 0);
                if (model_q.size() == 0) begin
                    check_eq("start_on_empty", model_q.size(), 1);
                end else begin
                    exp_b = model_q.pop_front();
                    check_eq("tx_data", u_if.tx_data, exp_b);
                    last_data = exp_b;
                end
            end else begin
                check_eq("tx_data_hold", u_if.tx_data, last_data);
            end
        end
        check_eq("count", u_if.count, model_q.size());
        check_eq("full", u_if.full, model_q.size() == DEPTH);
        check_eq("empty", u_if.empty, model_q.size() == 0);
        check_eq("overflow", u_if.overflow, model_ovf);
        prev_start = u_if.tx_start;
        pend_rst   = rst_n;
        pend_wr    = u_if.wr_en;
        pend_data  = u_if.wr_data;
        pend_clr   = u_if.clr_ovf;
        pend_busy  = u_if.tx_busy;
        // overflow for the coming edge depends on occupancy before that edge
        if (pend_rst && pend_wr && model_q.size() == DEPTH) model_ovf = 1'b1;
        else if (pend_rst && pend_clr)                       model_ovf = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        u_if.wr_en   = 1'b1;
        u_if.wr_data = d;
        tick();
        u_if.wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((model_q.size() != 0 || u_if.tx_busy) && n < max_cyc) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check_eq("drain_done", model_q.size(), 0);
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.wr_data = 8'h00;
        u_if.clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // single byte latency
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 8'h41;
        tick();
        u_if.wr_en   = 1'b0;
        check_eq("lat_stored", u_if.count, 1);
        check_eq("lat_no_start_yet", u_if.tx_start, 0);
        tick();
        check_eq("lat_start", u_if.tx_start, 1);
        check_eq("lat_data", u_if.tx_data, 8'h41);
        check_eq("lat_count0", u_if.count, 0);
        check_eq("lat_empty", u_if.empty, 1);
        busy_len = 4;
        wait_drain(200);

        // fill, overflow, clear priority
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) wr_byte(8'(i));
        check_eq("burst_full", u_if.full, 1);
        check_eq("burst_count16", u_if.count, 16);
        wr_byte(8'hAA);
        check_eq("ovf_set", u_if.overflow, 1);
        check_eq("ovf_count16", u_if.count, 16);
        u_if.clr_ovf = 1'b1;
        tick();
        u_if.clr_ovf = 1'b0;
        check_eq("ovf_cleared", u_if.overflow, 0);
        u_if.clr_ovf = 1'b1;
        wr_byte(8'hBB);
        u_if.clr_ovf = 1'b0;
        check_eq("ovf_set_beats_clr", u_if.overflow, 1);
        u_if.clr_ovf = 1'b1;
        tick();
        u_if.clr_ovf = 1'b0;
        base       = n_starts;
        busy_len   = 100;
        force_busy = 1'b0;
        wait_drain(3000);
        check_eq("burst_starts", n_starts - base, 16);

        // simultaneous write and pop at count 5, then 40-byte stream
        busy_len   = 2;
        base       = n_starts;
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) wr_byte(8'($urandom));
        check_eq("pre_count5", u_if.count, 5);
        force_busy   = 1'b0;
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 8'h77;
        tick();
        u_if.wr_en   = 1'b0;
        check_eq("wr_pop_start", u_if.tx_start, 1);
        check_eq("wr_pop_count5", u_if.count, 5);
        for (int i = 0; i < 40; i++) begin
            while (u_if.full) tick();
            wr_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_drain(3000);
        check_eq("stream_starts", n_starts - base, 46);

        // transmitter never goes busy: timeout path
        busy_len = 0;
        start_times.delete();
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        wait_drain(200);
        check_eq("to_starts", start_times.size(), 3);
        if (start_times.size() == 3) begin
            check_eq("to_gap1", start_times[1] - start_times[0], 4);
            check_eq("to_gap2", start_times[2] - start_times[1], 4);
        end

        // reset while transmitter busy with bytes queued
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) wr_byte(8'hC0 + 8'(i));
        check_eq("rst_pre_count", u_if.count, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_count0", u_if.count, 0);
        check_eq("rst_empty", u_if.empty, 1);
        base = n_starts;
        repeat (5) tick();
        check_eq("rst_no_start", n_starts - base, 0);
        force_busy = 1'b0;
        busy_len   = 3;
        wr_byte(8'h5A);
        wait_drain(200);
        check_eq("rst_after_start", n_starts - base, 1);

        // random traffic with random busy lengths and overflow clears
        rand_busy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            u_if.wr_en   = ($urandom_range(0, 1) == 1);
            u_if.wr_data = 8'($urandom);
            u_if.clr_ovf = ($urandom_range(0, 15) == 0);
            tick();
        end
        u_if.wr_en   = 1'b0;
        u_if.clr_ovf = 1'b0;
        wait_drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus drain state machine sitting directly upstream of the UART transmitter.
- Accepts bursts of bytes from on-chip producers (command responses, ADC sample dumps) at full clock rate.
- Issues them one at a time to the transmitter through its start/busy handshake, so producers never have to track transmitter timing.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ADDR_W, log2(DEPTH) = 4, pointer width; derived, not overridden.
- BUSY_TIMEOUT, 3, cycles to wait for tx_busy to rise after a tx_start pulse before treating the byte as sent.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write strobe; byte accepted when wr_en=1 and full=0
- wr_data  in  8  byte to enqueue
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  ADDR_W+1  bytes currently stored, 0..DEPTH
- overflow  out  1  sticky; set when wr_en=1 while full
- clr_ovf  in  1  clears overflow
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte for the transmitter; valid with tx_start, held afterwards
- tx_busy  in  1  transmitter busy flag

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst_n), sampled on posedge clk only.
- Reset values:
  - Pointers, count, tx_start, tx_data and overflow are all 0.
  - empty=1, full=0.
  - FSM in IDLE.
- Storage:
  - Circular buffer, write pointer wp and read pointer rp, each ADDR_W bits, wrapping DEPTH-1 -> 0.
  - count is a separate ADDR_W+1 counter.
  - full = (count==DEPTH); empty = (count==0).
- Write:
  - If wr_en and !full: mem[wp] <= wr_data; wp++.
  - If wr_en and full: byte dropped, pointers unchanged, overflow <= 1.
- overflow priority:
  - A set event in the same cycle as clr_ovf wins (overflow stays 1).
  - Otherwise clr_ovf clears it.
- Pop: occurs only in the cycle the FSM issues tx_start; rp++.
- count update when write and pop coincide:
  - Write accepted and pop in the same cycle: count unchanged.
  - Write while full and pop in the same cycle: write is dropped (full is evaluated on the pre-pop count) and overflow is set.
- FSM states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if !empty and !tx_busy, then tx_start <= 1, tx_data <= mem[rp], pop, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: tx_start <= 0.
    - If tx_busy=1, go to WAIT_DONE.
    - If tx_busy has not been seen after BUSY_TIMEOUT cycles in this state (3-bit counter), go to IDLE; the byte counts as sent.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- tx_start is registered and high for exactly one cycle per popped byte. It never asserts while tx_busy=1 or while in WAIT_BUSY/WAIT_DONE.
- Latency:
  - wr_en into an empty FIFO with FSM in IDLE and tx_busy=0 at cycle N: the byte is stored at edge N; tx_start=1 with that byte during cycle N+1.
  - Write-to-tx_start latency is therefore 1 cycle; there is no combinational path from wr_en to tx_start.
- Back-to-back bytes: the next tx_start comes no earlier than 1 cycle after tx_busy falls (WAIT_DONE -> IDLE -> start).
- tx_data holds its last value between starts; it changes only with tx_start.
- Reset mid-operation:
  - FIFO contents are discarded and the FSM returns to IDLE.
  - The transmitter may still be busy on an in-flight byte; IDLE waits for tx_busy=0 before the next start. No truncated or duplicated start is produced.
- Byte order is strictly FIFO; no byte is emitted twice or skipped except bytes dropped on overflow.

Test Plan:
- Reset, then write 0x41 at cycle 10 with tx_busy model idle -> tx_start pulse at cycle 11 with tx_data=0x41; count returns to 0, empty=1.
- Burst of 16 writes 0x00..0x0F in consecutive cycles, transmitter model busy 100 cycles per byte -> full=1 after the 16th accepted write; serial order 0x00..0x0F; exactly 16 tx_start pulses, each only after tx_busy fell.
- FIFO full, write 0xAA -> byte dropped, count stays 16, overflow=1. Next, clr_ovf pulse -> overflow=0. Then clr_ovf and an overflowing write in the same cycle -> overflow=1.
- Simultaneous accepted write and pop at count=5 -> count stays 5. Pointers wrap: 40 bytes streamed through DEPTH=16 arrive in order.
- Transmitter model never raises tx_busy after a start -> FSM returns to IDLE after 3 cycles and pops the next byte; no hang.
- Assert rst_n=0 for 1 cycle while tx_busy=1 with 5 bytes queued -> count=0, tx_start stays 0 until tx_busy falls. A new write afterwards is sent normally.
